level_engine: RTL and testbench

- Parametrised, clocked successor to the fixed-layout level blocks in the hero VGA game.
- Holds a loadable table of solid walls and breakable walls, and runs the bomb fuse/blast state machine.
- Clears breakable walls and flags player death on blast.
- Produces registered VGA colour and collision outputs; sits between the game controller (positions, bomb request) and the VGA mux.

---
 rtl/level_engine.sv | 219 +++++++++++++++++++++
 tb/tb_level_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/level_engine.sv
// Level engine: wall tables, bomb fuse/blast FSM, registered VGA colour and collision.
// Latency: colour and collision one cycle after inputs; no backpressure, every cycle accepted.
module level_engine #(
    parameter int NUM_WALLS   = 8,
    parameter int NUM_BWALLS  = 2,
    parameter int FUSE_TICKS  = 3,
    parameter int BLAST_RANGE = 20,
    parameter int CHAR_HX     = 13,
    parameter int CHAR_HY     = 28,
    parameter int BOMB_SIZE   = 10,
    parameter int SCREEN_W    = 635,
    parameter int SCREEN_H    = 475
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic                  enable,
    input  logic                  frame_tick,
    input  logic [9:0]            col,
    input  logic [9:0]            row,
    input  logic [9:0]            char_pos_x,
    input  logic [9:0]            char_pos_y,
    input  logic                  char_pix,
    input  logic                  bomb_drop,
    input  logic                  wr_en,
    input  logic                  wr_brk,
    input  logic [3:0]            wr_idx,
    input  logic [39:0]           wr_data,
    output logic [7:0]            VGA_R,
    output logic [7:0]            VGA_G,
    output logic [7:0]            VGA_B,
    output logic                  coll,
    output logic                  death,
    output logic                  bomb_busy,
    output logic [NUM_BWALLS-1:0] bwall_alive
);

    localparam int CW = $clog2(FUSE_TICKS + 1);
    localparam logic [CW-1:0]     LP_FT  = CW'(FUSE_TICKS);
    localparam logic signed [10:0] S_ZERO = '0;
    localparam logic signed [10:0] S_HX   = 11'(CHAR_HX);
    localparam logic signed [10:0] S_HY   = 11'(CHAR_HY);
    localparam logic signed [10:0] S_BS   = 11'(BOMB_SIZE);
    localparam logic signed [10:0] S_BR   = 11'(BLAST_RANGE);
    localparam logic signed [10:0] S_SW   = 11'(SCREEN_W);
    localparam logic signed [10:0] S_SH   = 11'(SCREEN_H);

    typedef enum logic [1:0] {ST_IDLE, ST_FUSE, ST_BLAST} state_t;

    // Slot layout {l,r,u,d}; l >= r marks the slot as unused.
    function automatic logic signed [10:0] f_fld(input logic [9:0] v);
        return $signed({1'b0, v});
    endfunction

    function automatic logic f_en(input logic [39:0] w);
        return w[39:30] < w[29:20];
    endfunction

    function automatic logic f_in_box(input logic [39:0] w,
                                      input logic signed [10:0] x,
                                      input logic signed [10:0] y);
        return (f_fld(w[39:30]) < x) && (x < f_fld(w[29:20])) &&
               (f_fld(w[19:10]) < y) && (y < f_fld(w[9:0]));
    endfunction

    function automatic logic f_overlap(input logic [39:0] w,
                                       input logic signed [10:0] bl,
                                       input logic signed [10:0] br,
                                       input logic signed [10:0] bu,
                                       input logic signed [10:0] bd);
        return f_en(w) && (bl <= f_fld(w[29:20])) && (br >= f_fld(w[39:30])) &&
               (bu <= f_fld(w[9:0])) && (bd >= f_fld(w[19:10]));
    endfunction

    logic [39:0]        r_wall  [NUM_WALLS];
    logic [39:0]        r_bwall [NUM_BWALLS];
    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic signed [10:0] r_bomb_x, r_bomb_y;
    logic               r_active_d;

    logic               w_run, w_drop_ok;
    logic signed [10:0] w_col, w_row, w_cx, w_cy;
    logic signed [10:0] w_char_l, w_char_r, w_char_u, w_char_d;
    logic signed [10:0] w_bomb_l, w_bomb_r, w_bomb_u, w_bomb_d;
    logic               w_solid_px, w_brk_px, w_bomb_px, w_char_px;
    logic               w_edge_hit, w_wall_hit, w_death_hit;
    logic [NUM_BWALLS-1:0] w_bclr;

    assign w_run     = active & enable;
    assign w_drop_ok = (r_state == ST_IDLE) && w_run && bomb_drop;
    assign w_col     = f_fld(col);
    assign w_row     = f_fld(row);
    assign w_cx      = f_fld(char_pos_x);
    assign w_cy      = f_fld(char_pos_y);
    assign w_char_l  = w_cx - S_HX;
    assign w_char_r  = w_cx + S_HX;
    assign w_char_u  = w_cy - S_HY;
    assign w_char_d  = w_cy + S_HY;
    assign w_bomb_l  = r_bomb_x - S_BS;
    assign w_bomb_r  = r_bomb_x + S_BS;
    assign w_bomb_u  = r_bomb_y - S_BS;
    assign w_bomb_d  = r_bomb_y + S_BS;

    assign VGA_G     = 8'h00;
    assign bomb_busy = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (wr_en && !active) begin
            for (int i = 0; i < NUM_WALLS; i++)
                if (!wr_brk && wr_idx == 4'(i)) r_wall[i] <= wr_data;
            for (int i = 0; i < NUM_BWALLS; i++)
                if (wr_brk && wr_idx == 4'(i)) r_bwall[i] <= wr_data;
        end
    end

    always_comb begin
        w_solid_px = 1'b0;
        w_brk_px   = 1'b0;
        w_wall_hit = 1'b0;
        w_bclr     = '0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            if (f_en(r_wall[i]) && f_in_box(r_wall[i], w_col, w_row)) w_solid_px = 1'b1;
            if (f_overlap(r_wall[i], w_char_l, w_char_r, w_char_u, w_char_d)) w_wall_hit = 1'b1;
        end
        for (int i = 0; i < NUM_BWALLS; i++) begin
            if (bwall_alive[i]) begin
                if (f_en(r_bwall[i]) && f_in_box(r_bwall[i], w_col, w_row)) w_brk_px = 1'b1;
                if (f_overlap(r_bwall[i], w_char_l, w_char_r, w_char_u, w_char_d)) w_wall_hit = 1'b1;
                // Vertical overlap plus horizontal gap under range on both sides.
                if (f_en(r_bwall[i]) &&
                    f_fld(r_bwall[i][19:10]) <= w_bomb_d && f_fld(r_bwall[i][9:0]) >= w_bomb_u &&
                    (f_fld(r_bwall[i][39:30]) - w_bomb_r) < S_BR &&
                    (w_bomb_l - f_fld(r_bwall[i][29:20])) < S_BR)
                    w_bclr[i] = 1'b1;
            end
        end
        w_bomb_px  = (r_state == ST_FUSE) &&
                     (w_bomb_l < w_col) && (w_col < w_bomb_r) &&
                     (w_bomb_u < w_row) && (w_row < w_bomb_d);
        w_char_px  = char_pix &&
                     (w_char_l <= w_col) && (w_col <= w_char_r) &&
                     (w_char_u <= w_row) && (w_row <= w_char_d);
        w_edge_hit = (w_char_l <= S_ZERO) || (w_char_r >= S_SW) ||
                     (w_char_u <= S_ZERO) || (w_char_d >= S_SH);
        w_death_hit = (w_char_l - S_BR <= w_bomb_r) && (w_char_r + S_BR >= w_bomb_l) &&
                      (w_char_u - S_BR <= w_bomb_d) && (w_char_d + S_BR >= w_bomb_u);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!w_run) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bomb_drop) begin
                        w_state_nxt = ST_FUSE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_FUSE: begin
                    if (frame_tick) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (r_cnt + 1'b1 == LP_FT) w_state_nxt = ST_BLAST;
                    end
                end
                ST_BLAST: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bomb_x    <= '0;
            r_bomb_y    <= '0;
            r_active_d  <= 1'b0;
            VGA_R       <= 8'h00;
            VGA_B       <= 8'h00;
            coll        <= 1'b0;
            death       <= 1'b0;
            bwall_alive <= '1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_active_d <= active;
            if (w_drop_ok) begin
                r_bomb_x <= w_cx;
                r_bomb_y <= w_cy + S_HY - S_BS;
            end
            if (w_run) begin
                VGA_R <= (w_solid_px ? 8'hFF : 8'h00) | (w_char_px ? 8'hC8 : 8'h00);
                VGA_B <= (w_brk_px || w_bomb_px) ? 8'hFF : 8'h00;
                coll  <= w_edge_hit || w_wall_hit;
            end else begin
                VGA_R <= 8'h00;
                VGA_B <= 8'h00;
                coll  <= 1'b0;
            end
            // A fresh activation is a level restart.
            if (active && !r_active_d) begin
                bwall_alive <= '1;
                death       <= 1'b0;
            end else if (r_state == ST_BLAST && w_run) begin
                bwall_alive <= bwall_alive & ~w_bclr;
                if (w_death_hit) death <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_level_engine.sv
// Directed bench for level_engine: drawing, collision, bomb fuse/blast, restart and reset.
module tb_level_engine;

    logic        clk = 1'b0;
    logic        rst, active, enable, frame_tick, char_pix, bomb_drop;
    logic        wr_en, wr_brk;
    logic [3:0]  wr_idx;
    logic [39:0] wr_data;
    logic [9:0]  col, row, char_pos_x, char_pos_y;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        coll, death, bomb_busy;
    logic [1:0]  bwall_alive;

    int checks = 0;
    int errors = 0;

    level_engine dut (
        .clk(clk), .rst(rst), .active(active), .enable(enable), .frame_tick(frame_tick),
        .col(col), .row(row), .char_pos_x(char_pos_x), .char_pos_y(char_pos_y),
        .char_pix(char_pix), .bomb_drop(bomb_drop), .wr_en(wr_en), .wr_brk(wr_brk),
        .wr_idx(wr_idx), .wr_data(wr_data), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .coll(coll), .death(death), .bomb_busy(bomb_busy), .bwall_alive(bwall_alive)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic brk, input logic [3:0] idx, input logic [39:0] d);
        wr_en = 1'b1; wr_brk = brk; wr_idx = idx; wr_data = d;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic put_char(input logic [9:0] x, input logic [9:0] y);
        char_pos_x = x; char_pos_y = y;
    endtask

    task automatic fuse_ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1; step(1);
            frame_tick = 1'b0; step(1);
        end
    endtask

    task automatic drop();
        bomb_drop = 1'b1; step(1);
        bomb_drop = 1'b0;
    endtask

    task automatic restart();
        active = 1'b0; step(1);
        active = 1'b1; step(1);
    endtask

    initial begin
        rst = 1'b1; active = 1'b0; enable = 1'b0; frame_tick = 1'b0; char_pix = 1'b0;
        bomb_drop = 1'b0; wr_en = 1'b0; wr_brk = 1'b0; wr_idx = '0; wr_data = '0;
        col = '0; row = '0; char_pos_x = 10'd300; char_pos_y = 10'd200;
        step(2);
        chk("rst_vga_r", VGA_R, 8'h00);
        chk("rst_vga_b", VGA_B, 8'h00);
        chk("rst_coll", coll, 1'b0);
        chk("rst_death", death, 1'b0);
        chk("rst_busy", bomb_busy, 1'b0);
        chk("rst_alive", bwall_alive, 2'b11);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) wr(1'b0, 4'(i), 40'd0);
        for (int i = 0; i < 2; i++) wr(1'b1, 4'(i), 40'd0);
        wr(1'b0, 4'd0, {10'd0, 10'd100, 10'd0, 10'd125});
        active = 1'b1; enable = 1'b1;

        col = 10'd50; row = 10'd60; step(1);
        chk("solid_r", VGA_R, 8'hFF);
        chk("solid_b", VGA_B, 8'h00);
        col = 10'd100; step(1);
        chk("solid_edge_r", VGA_R, 8'h00);
        col = 10'd300; row = 10'd200; char_pix = 1'b1; step(1);
        chk("char_pix_r", VGA_R, 8'hC8);
        char_pix = 1'b0;

        put_char(10'd110, 10'd60); step(1);
        chk("coll_wall", coll, 1'b1);
        put_char(10'd300, 10'd200); step(1);
        chk("coll_free", coll, 1'b0);
        put_char(10'd5, 10'd200); step(1);
        chk("coll_left_nowrap", coll, 1'b1);
        put_char(10'd300, 10'd200);

        wr(1'b0, 4'd1, {10'd0, 10'd600, 10'd0, 10'd470});
        step(1);
        chk("wr_while_active", coll, 1'b0);

        active = 1'b0;
        wr(1'b0, 4'd12, {10'd0, 10'd600, 10'd0, 10'd470});
        wr(1'b1, 4'd0, {10'd215, 10'd250, 10'd125, 10'd250});
        active = 1'b1; step(1);
        chk("wr_idx12_ignored", coll, 1'b0);
        col = 10'd230; row = 10'd200; step(1);
        chk("bwall_b", VGA_B, 8'hFF);
        chk("bwall_r", VGA_R, 8'h00);

        // Bomb next to the breakable wall, character in range.
        put_char(10'd190, 10'd180); drop();
        chk("fuse_busy", bomb_busy, 1'b1);
        col = 10'd190; row = 10'd198; step(1);
        chk("bomb_draw_b", VGA_B, 8'hFF);
        fuse_ticks(2);
        chk("fuse_alive_hold", bwall_alive, 2'b11);
        frame_tick = 1'b1; step(1); frame_tick = 1'b0;
        chk("blast_busy", bomb_busy, 1'b1);
        step(1);
        chk("after_blast_busy", bomb_busy, 1'b0);
        chk("blast_alive", bwall_alive, 2'b10);
        chk("blast_death", death, 1'b1);

        active = 1'b0; step(1);
        chk("deact_alive_hold", bwall_alive, 2'b10);
        chk("deact_death_hold", death, 1'b1);
        chk("deact_vga_b", VGA_B, 8'h00);
        active = 1'b1; step(1);
        chk("restart_alive", bwall_alive, 2'b11);
        chk("restart_death", death, 1'b0);

        // Character walks away before the blast.
        put_char(10'd190, 10'd180); drop();
        fuse_ticks(2);
        put_char(10'd400, 10'd180);
        fuse_ticks(1);
        chk("far_alive", bwall_alive, 2'b10);
        chk("far_death", death, 1'b0);
        restart();

        // Bomb too far left of the breakable wall.
        put_char(10'd150, 10'd180); drop();
        fuse_ticks(3);
        chk("gap_alive", bwall_alive, 2'b11);
        chk("gap_death", death, 1'b1);
        restart();

        // Second drop during fuse must not restart the count.
        put_char(10'd190, 10'd180); drop();
        fuse_ticks(1);
        drop(); step(1);
        fuse_ticks(1);
        chk("redrop_busy", bomb_busy, 1'b1);
        frame_tick = 1'b1; step(1); frame_tick = 1'b0;
        chk("redrop_blast", bomb_busy, 1'b1);
        step(1);
        chk("redrop_alive", bwall_alive, 2'b10);
        restart();

        // Drop and tick together: that tick does not count.
        bomb_drop = 1'b1; frame_tick = 1'b1; step(1);
        bomb_drop = 1'b0; frame_tick = 1'b0;
        fuse_ticks(2);
        chk("droptick_busy", bomb_busy, 1'b1);
        chk("droptick_alive", bwall_alive, 2'b11);
        fuse_ticks(1);
        chk("droptick_blast_alive", bwall_alive, 2'b10);
        restart();

        // Reset during the fuse.
        drop();
        fuse_ticks(2);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("rstfuse_busy", bomb_busy, 1'b0);
        chk("rstfuse_alive", bwall_alive, 2'b11);
        fuse_ticks(2);
        chk("rstfuse_noblast", bwall_alive, 2'b11);
        chk("rstfuse_death", death, 1'b0);

        // Enable low aborts the fuse and blanks the outputs.
        drop();
        enable = 1'b0; col = 10'd50; row = 10'd60; step(1);
        chk("disable_busy", bomb_busy, 1'b0);
        chk("disable_vga_r", VGA_R, 8'h00);
        enable = 1'b1; step(1);
        chk("enable_vga_r", VGA_R, 8'hFF);
        fuse_ticks(3);
        chk("disable_noblast", bwall_alive, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
